// File: rtl/sample_sdiv_11s6u_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_sdiv_11s6u_seq_pkg
// Description : Shared widths and FSM state encoding for the signed-by-unsigned
//               sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_sdiv_11s6u_seq_pkg;

    localparam int DEFAULT_DIVIDEND_WIDTH = 11;
    localparam int DEFAULT_DIVISOR_WIDTH  = 6;
    localparam int DEFAULT_REM_WIDTH      = DEFAULT_DIVISOR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } sdiv_state_t;

endpackage : sample_sdiv_11s6u_seq_pkg
`default_nettype wire

// File: rtl/sample_sdiv_restore_step.sv
`default_nettype none
// ============================================================================
// Module      : sample_sdiv_restore_step
// Description : One combinational restoring-division step: shift in a dividend
//               bit, compare against the divisor, conditionally subtract.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_sdiv_restore_step
    import sample_sdiv_11s6u_seq_pkg::*;
#(
    parameter int DIVISOR_WIDTH = DEFAULT_DIVISOR_WIDTH
) (
    input  logic [DIVISOR_WIDTH-1:0] i_rem,
    input  logic                     i_dvd_bit,
    input  logic [DIVISOR_WIDTH-1:0] i_divisor,
    output logic [DIVISOR_WIDTH:0]   o_rem,
    output logic                     o_q_bit
);

    logic [DIVISOR_WIDTH:0] w_shifted;
    logic [DIVISOR_WIDTH:0] w_diff;

    // The incoming remainder is always below the divisor, so its low bits carry it all.
    assign w_shifted = {i_rem, i_dvd_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign o_q_bit   = (w_shifted >= {1'b0, i_divisor});
    assign o_rem     = o_q_bit ? w_diff : w_shifted;

endmodule : sample_sdiv_restore_step
`default_nettype wire

// File: rtl/sample_sdiv_11s6u_seq.sv
`default_nettype none
// ============================================================================
// Module      : sample_sdiv_11s6u_seq
// Description : Multi-cycle truncating signed/unsigned restoring divider with
//               ap_ctrl_hs start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_sdiv_11s6u_seq
    import sample_sdiv_11s6u_seq_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEFAULT_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEFAULT_DIVISOR_WIDTH
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic                             ap_start,
    output logic                             ap_done,
    output logic                             ap_idle,
    output logic                             ap_ready,
    input  logic signed [DIVIDEND_WIDTH-1:0] din0,
    input  logic        [DIVISOR_WIDTH-1:0]  din1,
    output logic signed [DIVIDEND_WIDTH-1:0] quot,
    output logic signed [DIVISOR_WIDTH:0]    rem,
    output logic                             dbz
);

    localparam int REM_WIDTH = DIVISOR_WIDTH + 1;
    localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH);

    sdiv_state_t                r_state;
    sdiv_state_t                w_state_next;
    logic                       r_sign;
    logic [DIVIDEND_WIDTH-1:0]  r_work;
    logic [REM_WIDTH-1:0]       r_prem;
    logic [DIVISOR_WIDTH-1:0]   r_dvs;
    logic [CNT_WIDTH-1:0]       r_cnt;

    logic [DIVIDEND_WIDTH-1:0]  w_dvd_abs;
    logic [REM_WIDTH-1:0]       w_step_rem;
    logic                       w_step_q;
    logic                       w_accept;

    // Magnitude of the most negative dividend still fits as an unsigned value.
    assign w_dvd_abs = din0[DIVIDEND_WIDTH-1] ? (~din0 + 1'b1) : din0;
    assign w_accept  = (r_state == IDLE) && ap_start;

    sample_sdiv_restore_step #(
        .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_step (
        .i_rem     (r_prem[DIVISOR_WIDTH-1:0]),
        .i_dvd_bit (r_work[DIVIDEND_WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_q)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ap_idle      = 1'b0;
        ap_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_state_next = DONE;
            end
            DONE: begin
                ap_done      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign ap_ready = ap_done;

    // r_work shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sign <= 1'b0;
            r_work <= '0;
            r_prem <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            quot   <= '0;
            rem    <= '0;
            dbz    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign <= din0[DIVIDEND_WIDTH-1];
                r_work <= w_dvd_abs;
                r_prem <= '0;
                r_dvs  <= din1;
                r_cnt  <= CNT_WIDTH'(DIVIDEND_WIDTH - 1);
            end
            if (r_state == CALC) begin
                r_prem <= w_step_rem;
                r_work <= {r_work[DIVIDEND_WIDTH-2:0], w_step_q};
                r_cnt  <= r_cnt - 1'b1;
            end
            if (r_state == FIX) begin
                if (r_dvs == '0) begin
                    quot <= '0;
                    rem  <= '0;
                    dbz  <= 1'b1;
                end else begin
                    quot <= r_sign ? -r_work : r_work;
                    rem  <= r_sign ? -r_prem : r_prem;
                    dbz  <= 1'b0;
                end
            end
        end
    end

endmodule : sample_sdiv_11s6u_seq
`default_nettype wire

// File: tb/tb_sample_sdiv_11s6u_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_sdiv_11s6u_seq
// Description : Directed self-checking bench for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_sdiv_11s6u_seq;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic               ap_start;
    logic               ap_done;
    logic               ap_idle;
    logic               ap_ready;
    logic signed [10:0] din0;
    logic        [5:0]  din1;
    logic signed [10:0] quot;
    logic signed [6:0]  rem;
    logic               dbz;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ap_clk = ~ap_clk;

    sample_sdiv_11s6u_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .din0     (din0),
        .din1     (din1),
        .quot     (quot),
        .rem      (rem),
        .dbz      (dbz)
    );

    // Launch one operation and wait (bounded) for its done pulse; lat is the
    // cycle index of ap_done counted from the accept edge, -1 on timeout.
    task automatic do_op(input logic signed [10:0] a, input logic [5:0] b,
                         output int lat, output logic signed [10:0] q,
                         output logic signed [6:0] r, output logic z, output logic rdy);
        @(negedge ap_clk);
        din0 = a; din1 = b; ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        lat = -1; q = '0; r = '0; z = 1'b0; rdy = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (ap_done) begin
                lat = k; q = quot; r = rem; z = dbz; rdy = ap_ready;
                break;
            end
            @(negedge ap_clk);
        end
    endtask

    task automatic test_reset();
        n_tests++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", ap_idle); end
        n_tests++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", ap_done); end
        n_tests++; if (ap_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ap_ready); end
        n_tests++; if (quot !== 11'sd0) begin n_fail++; $display("FAIL reset_quot got %0d want 0", quot); end
        n_tests++; if (rem !== 7'sd0) begin n_fail++; $display("FAIL reset_rem got %0d want 0", rem); end
        n_tests++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", dbz); end
    endtask

    task automatic test_basic();
        int lat; logic signed [10:0] q; logic signed [6:0] r; logic z, rdy;
        do_op(11'sd100, 6'd7, lat, q, r, z, rdy);
        n_tests++; if (lat !== 13) begin n_fail++; $display("FAIL basic_latency got %0d want 13", lat); end
        n_tests++; if (q !== 11'sd14) begin n_fail++; $display("FAIL basic_quot got %0d want 14", q); end
        n_tests++; if (r !== 7'sd2) begin n_fail++; $display("FAIL basic_rem got %0d want 2", r); end
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %b want 0", z); end
        n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b want 1", rdy); end
        @(negedge ap_clk);
        n_tests++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", ap_done); end
        n_tests++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL basic_idle_back got %b want 1", ap_idle); end
    endtask

    task automatic test_signed();
        int lat; logic signed [10:0] q; logic signed [6:0] r; logic z, rdy;
        do_op(-11'sd100, 6'd7, lat, q, r, z, rdy);
        n_tests++; if (q !== -11'sd14) begin n_fail++; $display("FAIL neg100_quot got %0d want -14", q); end
        n_tests++; if (r !== -7'sd2) begin n_fail++; $display("FAIL neg100_rem got %0d want -2", r); end
        do_op(-11'sd1024, 6'd1, lat, q, r, z, rdy);
        n_tests++; if (q !== -11'sd1024) begin n_fail++; $display("FAIL min_quot got %0d want -1024", q); end
        n_tests++; if (r !== 7'sd0) begin n_fail++; $display("FAIL min_rem got %0d want 0", r); end
        n_tests++; if (lat !== 13) begin n_fail++; $display("FAIL min_latency got %0d want 13", lat); end
    endtask

    task automatic test_boundary();
        int lat; logic signed [10:0] q; logic signed [6:0] r; logic z, rdy;
        do_op(11'sd1023, 6'd63, lat, q, r, z, rdy);
        n_tests++; if (q !== 11'sd16) begin n_fail++; $display("FAIL max_quot got %0d want 16", q); end
        n_tests++; if (r !== 7'sd15) begin n_fail++; $display("FAIL max_rem got %0d want 15", r); end
        do_op(11'sd5, 6'd63, lat, q, r, z, rdy);
        n_tests++; if (q !== 11'sd0) begin n_fail++; $display("FAIL small_quot got %0d want 0", q); end
        n_tests++; if (r !== 7'sd5) begin n_fail++; $display("FAIL small_rem got %0d want 5", r); end
    endtask

    task automatic test_dbz();
        int lat; logic signed [10:0] q; logic signed [6:0] r; logic z, rdy;
        do_op(-11'sd37, 6'd0, lat, q, r, z, rdy);
        n_tests++; if (lat !== 13) begin n_fail++; $display("FAIL dbz_latency got %0d want 13", lat); end
        n_tests++; if (q !== 11'sd0) begin n_fail++; $display("FAIL dbz_quot got %0d want 0", q); end
        n_tests++; if (r !== 7'sd0) begin n_fail++; $display("FAIL dbz_rem got %0d want 0", r); end
        n_tests++; if (z !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %b want 1", z); end
        do_op(11'sd9, 6'd3, lat, q, r, z, rdy);
        n_tests++; if (q !== 11'sd3) begin n_fail++; $display("FAIL after_dbz_quot got %0d want 3", q); end
        n_tests++; if (r !== 7'sd0) begin n_fail++; $display("FAIL after_dbz_rem got %0d want 0", r); end
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL after_dbz_flag got %b want 0", z); end
    endtask

    task automatic test_busy_ignore();
        int lat = -1;
        @(negedge ap_clk);
        din0 = 11'sd20; din1 = 6'd3; ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        din0 = 11'sd99; din1 = 6'd5; ap_start = 1'b1;
        n_tests++; if (ap_idle !== 1'b0) begin n_fail++; $display("FAIL busy_idle got %b want 0", ap_idle); end
        @(negedge ap_clk);
        ap_start = 1'b0;
        for (int k = 5; k <= 40; k++) begin
            if (ap_done) begin lat = k; break; end
            @(negedge ap_clk);
        end
        n_tests++; if (lat !== 13) begin n_fail++; $display("FAIL busy_latency got %0d want 13", lat); end
        n_tests++; if (quot !== 11'sd6) begin n_fail++; $display("FAIL busy_quot got %0d want 6", quot); end
        n_tests++; if (rem !== 7'sd2) begin n_fail++; $display("FAIL busy_rem got %0d want 2", rem); end
        repeat (3) @(negedge ap_clk);
        n_tests++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL busy_no_restart got %b want 1", ap_idle); end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        logic signed [10:0] q1 = '0, q2 = '0;
        logic signed [6:0]  r1 = '0, r2 = '0;
        @(negedge ap_clk);
        din0 = 11'sd30; din1 = 6'd4; ap_start = 1'b1;
        @(negedge ap_clk);
        for (int k = 1; k <= 60; k++) begin
            if (ap_done) begin
                if (first < 0) begin
                    first = k; q1 = quot; r1 = rem;
                    din0 = -11'sd30; din1 = 6'd4;
                end else begin
                    second = k; q2 = quot; r2 = rem;
                    break;
                end
            end
            @(negedge ap_clk);
        end
        ap_start = 1'b0;
        n_tests++; if (first !== 13) begin n_fail++; $display("FAIL b2b_first got %0d want 13", first); end
        n_tests++; if (second !== 27) begin n_fail++; $display("FAIL b2b_second got %0d want 27", second); end
        n_tests++; if (q1 !== 11'sd7 || r1 !== 7'sd2) begin n_fail++; $display("FAIL b2b_res1 got %0d r %0d want 7 r 2", q1, r1); end
        n_tests++; if (q2 !== -11'sd7 || r2 !== -7'sd2) begin n_fail++; $display("FAIL b2b_res2 got %0d r %0d want -7 r -2", q2, r2); end
        @(negedge ap_clk);
    endtask

    task automatic test_reset_abort();
        int lat; logic signed [10:0] q; logic signed [6:0] r; logic z, rdy;
        int done_seen = 0;
        @(negedge ap_clk);
        din0 = 11'sd77; din1 = 6'd5; ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (5) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        n_tests++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL abort_idle got %b want 1", ap_idle); end
        n_tests++; if (quot !== 11'sd0) begin n_fail++; $display("FAIL abort_quot got %0d want 0", quot); end
        n_tests++; if (rem !== 7'sd0 || dbz !== 1'b0) begin n_fail++; $display("FAIL abort_rem_dbz got %0d/%b want 0/0", rem, dbz); end
        repeat (3) begin @(negedge ap_clk); if (ap_done) done_seen++; end
        ap_rst_n = 1'b1;
        repeat (15) begin @(negedge ap_clk); if (ap_done) done_seen++; end
        n_tests++; if (done_seen !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", done_seen); end
        n_tests++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL abort_stay_idle got %b want 1", ap_idle); end
        do_op(11'sd50, 6'd6, lat, q, r, z, rdy);
        n_tests++; if (q !== 11'sd8 || r !== 7'sd2) begin n_fail++; $display("FAIL abort_restart got %0d r %0d want 8 r 2", q, r); end
        n_tests++; if (lat !== 13) begin n_fail++; $display("FAIL abort_restart_latency got %0d want 13", lat); end
    endtask

    initial begin
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (2) @(negedge ap_clk);
        test_reset();
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        test_basic();
        test_signed();
        test_boundary();
        test_dbz();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sample_sdiv_11s6u_seq
`default_nettype wire
